// File: rtl/iiitb_cg_pkg.sv
// Shared constants for the clock-gate enable controller: state encoding and
// default timing parameters.
package iiitb_cg_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_OFF  = 2'b00,
    S_WAKE = 2'b01,
    S_ON   = 2'b10,
    S_HOLD = 2'b11
  } cg_state_e;

  localparam int unsigned WAKE_CYCLES_DEF = 2;
  localparam int unsigned IDLE_CYCLES_DEF = 4;

endpackage

// File: rtl/iiitb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module iiitb_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Enable controller for a latch-based ICG cell: wake-up interval, idle timeout
// and saturating power statistics. All outputs come straight from registers.
module iiitb_cg_ctrl
  import iiitb_cg_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic               force_on,
  input  logic               clear_stats,
  output logic               gate_en,
  output logic               ready,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   off_cycles,
  output logic [CNT_W-1:0]   wake_events
);

  localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int unsigned IdleW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);

  cg_state_e        state_q;
  logic             gate_en_q;
  logic             ready_q;
  logic [WakeW-1:0] wake_cnt_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic             act;

  assign act = (|req) | force_on;

  // gate_en/ready are updated alongside the state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OFF;
      gate_en_q  <= 1'b0;
      ready_q    <= 1'b0;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (act) begin
            state_q    <= S_WAKE;
            gate_en_q  <= 1'b1;
            wake_cnt_q <= '0;
          end
        end
        S_WAKE: begin
          // Activity is ignored here: a started wake-up always completes.
          if (wake_cnt_q == WakeLast) begin
            state_q <= S_ON;
            ready_q <= 1'b1;
          end else begin
            wake_cnt_q <= wake_cnt_q + WakeW'(1);
          end
        end
        S_ON: begin
          if (!act) begin
            state_q    <= S_HOLD;
            idle_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (act) begin
            state_q    <= S_ON;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IdleLast) begin
            state_q   <= S_OFF;
            gate_en_q <= 1'b0;
            ready_q   <= 1'b0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleW'(1);
          end
        end
        default: begin
          state_q   <= S_OFF;
          gate_en_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  logic in_off;
  assign in_off = (state_q == S_OFF);

  iiitb_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_off_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clear_stats),
    .inc_i (in_off),
    .cnt_o (off_cycles)
  );

  iiitb_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_wake_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clear_stats),
    .inc_i (in_off & act),
    .cnt_o (wake_events)
  );

  assign gate_en = gate_en_q;
  assign ready   = ready_q;
  assign state   = state_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Self-checking bench for iiitb_cg_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a timestamp-based model.
module tb_iiitb_cg_ctrl;

  localparam int NREQ  = 2;
  localparam int WAKE  = 2;
  localparam int IDLE  = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic             force_on = 1'b0;
  logic             clear_stats = 1'b0;
  logic             gate_en;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] off_cycles;
  logic [CNT_W-1:0] wake_events;

  always #5 clk = ~clk;

  iiitb_cg_ctrl #(
    .NREQ        (NREQ),
    .WAKE_CYCLES (WAKE),
    .IDLE_CYCLES (IDLE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .force_on    (force_on),
    .clear_stats (clear_stats),
    .gate_en     (gate_en),
    .ready       (ready),
    .state       (state),
    .off_cycles  (off_cycles),
    .wake_events (wake_events)
  );

  int checks = 0;
  int failures = 0;

  // Model: the domain is "running" from the activating edge; ready once WAKE
  // edges have passed; it stops after IDLE+1 consecutive quiet edges in ON/HOLD.
  bit m_run = 0;
  int m_k = 0;
  int m_ws = 0;
  int m_quiet = 0;
  int m_off = 0;
  int m_wk = 0;

  function automatic void model_edge(bit r, bit a, bit c);
    bit pre_off;
    m_k++;
    if (r) begin
      m_run = 0; m_quiet = 0; m_off = 0; m_wk = 0;
      return;
    end
    pre_off = !m_run;
    if (c) begin
      m_off = 0; m_wk = 0;
    end else begin
      if (pre_off && m_off < SAT) m_off++;
      if (pre_off && a && m_wk < SAT) m_wk++;
    end
    if (!m_run) begin
      if (a) begin
        m_run = 1; m_ws = m_k; m_quiet = 0;
      end
    end else if (m_k > m_ws + WAKE) begin
      m_quiet = a ? 0 : m_quiet + 1;
      if (m_quiet == IDLE + 1) m_run = 0;
    end
  endfunction

  function automatic logic [11:0] model_exp();
    logic [1:0] st;
    logic       rd;
    rd = m_run && (m_k >= m_ws + WAKE);
    if (!m_run) st = 2'd0;
    else if (m_k < m_ws + WAKE) st = 2'd1;
    else if (m_quiet == 0) st = 2'd2;
    else st = 2'd3;
    return {m_run, rd, st, 4'(m_off), 4'(m_wk)};
  endfunction

  function automatic logic [11:0] pack(bit g, bit rd, logic [1:0] st, int off, int wk);
    return {g, rd, st, 4'(off), 4'(wk)};
  endfunction

  task automatic check(string name, logic [11:0] exp);
    logic [11:0] got;
    got = {gate_en, ready, state, off_cycles, wake_events};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got gate=%b ready=%b state=%b off=%0d wake=%0d, want gate=%b ready=%b state=%b off=%0d wake=%0d",
               name, $time, got[11], got[10], got[9:8], got[7:4], got[3:0],
               exp[11], exp[10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step(bit r, logic [NREQ-1:0] rq, bit f, bit c);
    @(negedge clk);
    rst = r; req = rq; force_on = f; clear_stats = c;
    @(posedge clk);
    model_edge(r, (|rq) | f, c);
    #1;
  endtask

  typedef struct {
    bit              r;
    logic [NREQ-1:0] rq;
    bit              f;
    bit              c;
    logic [11:0]     exp;
  } vec_t;

  vec_t tbl[64];
  int   n_tbl = 0;

  function automatic void add(bit r, logic [1:0] rq, bit f, bit c,
                              bit g, bit rd, logic [1:0] st, int off, int wk);
    tbl[n_tbl] = '{r: r, rq: rq, f: f, c: c, exp: pack(g, rd, st, off, wk)};
    n_tbl++;
  endfunction

  initial begin
    logic [1:0] pulse_st[8];
    int         hi;

    // Reset, idle, wake latency, HOLD re-entry, idle timeout, force_on, reset in ON.
    add(1, 2'b00, 0, 0, 0, 0, 2'd0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 2'b00, 0, 0, 0, 0, 2'd0, i, 0);
    add(0, 2'b01, 0, 0, 1, 0, 2'd1, 11, 1);
    add(0, 2'b01, 0, 0, 1, 0, 2'd1, 11, 1);
    add(0, 2'b01, 0, 0, 1, 1, 2'd2, 11, 1);
    add(0, 2'b00, 0, 0, 1, 1, 2'd3, 11, 1);
    add(0, 2'b10, 0, 0, 1, 1, 2'd2, 11, 1);
    for (int i = 0; i < 4; i++) add(0, 2'b00, 0, 0, 1, 1, 2'd3, 11, 1);
    add(0, 2'b00, 0, 0, 0, 0, 2'd0, 11, 1);
    add(0, 2'b00, 0, 0, 0, 0, 2'd0, 12, 1);
    add(0, 2'b00, 1, 0, 1, 0, 2'd1, 13, 2);
    add(0, 2'b00, 1, 0, 1, 0, 2'd1, 13, 2);
    for (int i = 0; i < 6; i++) add(0, 2'b00, 1, 0, 1, 1, 2'd2, 13, 2);
    add(1, 2'b00, 1, 0, 0, 0, 2'd0, 0, 0);
    add(0, 2'b00, 0, 0, 0, 0, 2'd0, 1, 0);

    for (int i = 0; i < n_tbl; i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].f, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // One-cycle pulse from OFF: WAKE(2) -> ON(1) -> HOLD(4) -> OFF.
    pulse_st = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    step(1, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, (i == 0) ? 2'b10 : 2'b00, 0, 0);
      if (gate_en) hi++;
      if (i < 8) check_int($sformatf("pulse_state%0d", i), int'(state), int'(pulse_st[i]));
    end
    check_int("pulse_gate_cycles", hi, 7);

    // Saturation of off_cycles, then clear coinciding with OFF->WAKE.
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 2'b00, 0, 0);
    check("off_saturate", pack(0, 0, 2'd0, SAT, 0));
    step(0, 2'b01, 0, 1);
    check("clear_on_wake", pack(1, 0, 2'd1, 0, 0));
    step(0, 2'b01, 0, 0);
    check("after_clear", pack(1, 0, 2'd1, 0, 0));

    // Randomized traffic against the model.
    step(1, 2'b00, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit               r, f, c;
      logic [NREQ-1:0]  rq;
      r  = ($urandom_range(0, 149) == 0);
      f  = ($urandom_range(0, 29) == 0);
      c  = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 4) == 0) ? NREQ'($urandom_range(1, 3)) : '0;
      step(r, rq, f, c);
      check($sformatf("rand%0d", i), model_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iiitb_cg_ctrl.md
Name: iiitb_cg_ctrl

Overview:
- Enable controller for the latch-based integrated clock-gating cell.
- Watches activity requests from NREQ requesters and drives the cell's enable (gate_en).
- Runs a fixed wake-up interval before declaring the gated domain ready.
- After activity stops, holds the clock on for an idle timeout, then gates it off.
- Keeps saturating power statistics (gated-off cycles and wake-up events) for software.

Parameters:
- NREQ, 2, number of activity-request inputs (≥1).
- WAKE_CYCLES, 2, cycles gate_en is high before ready asserts (≥1).
- IDLE_CYCLES, 4, consecutive inactive cycles in HOLD before gating off (≥1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  ungated system clock; also feeds the ICG cell.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester activity request, level-sensitive.
- force_on  input  1  override: keep the clock enabled while high.
- clear_stats  input  1  one-cycle pulse that zeroes both statistics counters.
- gate_en  output  1  enable to the ICG latch; registered.
- ready  output  1  gated domain clock stable; requesters may proceed.
- state  output  2  current FSM state, for debug.
- off_cycles  output  CNT_W  saturating count of cycles spent in OFF.
- wake_events  output  CNT_W  saturating count of OFF→WAKE transitions.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- Define act = |req | force_on, sampled at each rising clk edge.
- Reset values: state=OFF, gate_en=0, ready=0, wake and idle counters=0, off_cycles=0, wake_events=0.
- rst mid-operation returns to OFF on the next edge from any state. gate_en drops immediately; no drain.
- State encoding: OFF=2'b00, WAKE=2'b01, ON=2'b10, HOLD=2'b11.
- OFF: gate_en=0, ready=0.
  - act=1 → WAKE, with wake counter loaded to 0 and wake_events incremented.
  - Otherwise stay in OFF.
- WAKE: gate_en=1, ready=0. The wake counter increments every cycle.
  - When the counter reaches WAKE_CYCLES-1 → ON.
  - WAKE is never aborted: if act drops during WAKE, the block still completes to ON.
- ON: gate_en=1, ready=1.
  - act=0 → HOLD, with idle counter loaded to 0.
- HOLD: gate_en=1, ready=1.
  - act=1 → ON, with idle counter cleared.
  - Otherwise, if the idle counter is IDLE_CYCLES-1 → OFF; else the idle counter increments.
- Latency:
  - act rising at edge n puts gate_en high from n+1.
  - ready rises from n+1+WAKE_CYCLES.
  - The last active cycle at edge m puts gate_en low from m+1+IDLE_CYCLES, provided no further activity arrives.
- off_cycles: +1 each cycle state==OFF; saturates at all-ones. wake_events: saturates at all-ones.
- clear_stats has priority over increment in the same cycle. A simultaneous OFF→WAKE transition is not counted.
- req bits are ORed with no arbitration. force_on alone behaves exactly like a request.

Decomposition:
- Shared package iiitb_cg_pkg holds:
  - state localparams (S_OFF, S_WAKE, S_ON, S_HOLD);
  - the state width constant;
  - the defaults for WAKE_CYCLES and IDLE_CYCLES.
- One sub-module: iiitb_sat_cnt, a CNT_W-wide saturating counter with sync clear and inc inputs, where clear wins. It is instantiated twice, for off_cycles and wake_events.
- The FSM and the wake/idle counters stay in the top module.

Test Plan:
- Reset/idle: hold rst for 2 cycles, then req=0 for 10 cycles.
  - gate_en=0, ready=0, state=00 throughout.
  - off_cycles=10, wake_events=0.
- Wake latency: req[0]=1 at edge 5.
  - gate_en=1 from cycle 6.
  - ready=1 from cycle 8 (WAKE_CYCLES=2).
  - wake_events=1.
- Idle timeout: from ON, drop req at edge 20.
  - HOLD for 4 cycles, gate_en low from cycle 25.
  - req[1] pulse at cycle 23 returns the FSM to ON, with gate_en never dropping.
- Wake not aborted: one-cycle req pulse from OFF.
  - Sequence is WAKE(2)→ON(1)→HOLD(4)→OFF.
  - gate_en high for exactly 7 cycles.
- force_on and mid-operation reset: force_on=1 with req=0 keeps the FSM in ON indefinitely.
  - Asserting rst during ON gives gate_en=0 and state=00 on the next edge.
- Statistics: preload off_cycles near saturation with CNT_W=4 (more than 15 OFF cycles), so it holds at 15.
  - clear_stats coinciding with an OFF→WAKE transition gives wake_events=0.
